// File: rtl/log_capture_ctrl.sv
// Purpose: capture decimated datapath samples into a local RAM, then serve word reads.
// Latency: a sample is in RAM one edge after its strobe; readback address to o_data_log is 2 edges.
// Backpressure: none; the sample stream is never stalled, samples past a full buffer are dropped.
//
// Ports:
//   clk, i_rst        single clock, synchronous active-high reset
//   i_run_log         capture level; a rising edge (re)starts a capture
//   i_read_log        readback level, honoured in IDLE/FULL/READ
//   i_addr_log        readback word address
//   i_decim           keep one of every (i_decim+1) valid samples
//   i_sample(_valid)  datapath sample stream
//   o_data_log        registered readback data
//   o_mem_full        every RAM word written by the last capture
//   o_capturing       high while in CAPTURE
//   o_wr_count        words written by the current/last capture
module log_capture_ctrl #(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 32,
  parameter int NB_DEC  = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_ADDR-1:0] i_addr_log,
  input  logic [NB_DEC-1:0]  i_decim,
  input  logic [NB_DATA-1:0] i_sample,
  input  logic               i_sample_valid,
  output logic [NB_DATA-1:0] o_data_log,
  output logic               o_mem_full,
  output logic               o_capturing,
  output logic [NB_ADDR:0]   o_wr_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FULL, READ} state_t;

  state_t             state;
  logic               run_prev;
  logic               run_rise;
  logic [NB_ADDR-1:0] wr_addr;
  logic [NB_DEC-1:0]  dec_cnt;
  logic [NB_DEC-1:0]  dec_lim;
  logic               wr_en;
  logic               last_wr;
  logic               rd_stage;   // a RAM read was issued last edge; forward it to o_data_log
  logic [NB_DATA-1:0] ram_q;
  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  assign run_rise = i_run_log & ~run_prev;

  // A restart edge never writes; reset also blocks the write on the reset edge.
  assign wr_en   = (state == CAPTURE) & i_sample_valid & (dec_cnt == '0) & ~run_rise & ~i_rst;
  assign last_wr = wr_en & (wr_addr == {NB_ADDR{1'b1}});

  // RAM: no reset, contents survive i_rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= i_sample;
    end
    if (state == READ) begin
      ram_q <= mem[i_addr_log];
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= IDLE;
      run_prev    <= 1'b0;
      wr_addr     <= '0;
      dec_cnt     <= '0;
      dec_lim     <= '0;
      rd_stage    <= 1'b0;
      o_data_log  <= '0;
      o_mem_full  <= 1'b0;
      o_capturing <= 1'b0;
      o_wr_count  <= '0;
    end else begin
      run_prev <= i_run_log;
      rd_stage <= (state == READ);
      if (rd_stage) begin
        o_data_log <= ram_q;
      end

      if (run_rise) begin
        state       <= CAPTURE;
        o_capturing <= 1'b1;
        wr_addr     <= '0;
        o_wr_count  <= '0;
        dec_cnt     <= '0;
        o_mem_full  <= 1'b0;
        dec_lim     <= i_decim;
      end else begin
        case (state)
          CAPTURE: begin
            if (i_sample_valid) begin
              if (dec_cnt == '0) begin
                wr_addr    <= wr_addr + NB_ADDR'(1);
                o_wr_count <= o_wr_count + (NB_ADDR+1)'(1);
              end
              dec_cnt <= (dec_cnt == dec_lim) ? '0 : dec_cnt + NB_DEC'(1);
            end
            // Filling the last word wins over a simultaneous abort.
            if (last_wr) begin
              state       <= FULL;
              o_mem_full  <= 1'b1;
              o_capturing <= 1'b0;
            end else if (!i_run_log) begin
              state       <= IDLE;
              o_capturing <= 1'b0;
            end
          end
          IDLE, FULL: begin
            if (i_read_log) state <= READ;
          end
          READ: begin
            if (!i_read_log) state <= o_mem_full ? FULL : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Purpose: directed self-checking bench for log_capture_ctrl with a 16-word buffer.
// Latency: inputs change 1 time unit after a rising edge, outputs are checked at that point.
// Backpressure: not applicable; the stream is driven open loop.
module tb_log_capture_ctrl;

  localparam int NB_ADDR = 4;
  localparam int NB_DATA = 32;
  localparam int NB_DEC  = 4;

  localparam logic [1:0] S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_FULL = 2'd2, S_READ = 2'd3;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_run_log;
  logic               i_read_log;
  logic [NB_ADDR-1:0] i_addr_log;
  logic [NB_DEC-1:0]  i_decim;
  logic [NB_DATA-1:0] i_sample;
  logic               i_sample_valid;
  logic [NB_DATA-1:0] o_data_log;
  logic               o_mem_full;
  logic               o_capturing;
  logic [NB_ADDR:0]   o_wr_count;

  int vectors    = 0;
  int miscompares = 0;

  log_capture_ctrl #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_DEC(NB_DEC)) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_run_log      (i_run_log),
    .i_read_log     (i_read_log),
    .i_addr_log     (i_addr_log),
    .i_decim        (i_decim),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_data_log     (o_data_log),
    .o_mem_full     (o_mem_full),
    .o_capturing    (o_capturing),
    .o_wr_count     (o_wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enter READ, present one address, check the word two edges later, leave READ.
  task automatic read_one(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] exp, input string tag);
    i_read_log = 1'b1;
    step();
    i_addr_log = a;
    step();
    step();
    chk(tag, o_data_log, exp);
    i_read_log = 1'b0;
    step();
  endtask

  initial begin
    logic [NB_DATA-1:0] held;

    // 1. Reset with random inputs
    i_rst = 1'b1;
    i_run_log = 1'($urandom);
    i_read_log = 1'($urandom);
    i_addr_log = NB_ADDR'($urandom);
    i_decim = NB_DEC'($urandom);
    i_sample = $urandom;
    i_sample_valid = 1'($urandom);
    step();
    i_run_log = 1'b1;
    i_sample_valid = 1'b1;
    step();
    chk("rst_data", o_data_log, 0);
    chk("rst_full", o_mem_full, 0);
    chk("rst_capt", o_capturing, 0);
    chk("rst_cnt", o_wr_count, 0);
    chk("rst_state", dut.state, S_IDLE);
    i_rst = 1'b0;
    i_run_log = 1'b0;
    i_read_log = 1'b1;
    i_sample_valid = 1'b0;
    i_decim = '0;
    i_addr_log = '0;
    step();
    chk("rst_to_read", dut.state, S_READ);
    i_read_log = 1'b0;
    step();
    chk("read_to_idle", dut.state, S_IDLE);

    // 2. Full capture, decim 0, samples 0,1,2,...
    i_run_log = 1'b1;
    i_sample_valid = 1'b1;
    i_sample = 32'hDEAD;           // presented at the start edge, not stored
    step();
    chk("start_capt", o_capturing, 1);
    chk("start_cnt", o_wr_count, 0);
    for (int k = 0; k < 16; k++) begin
      i_sample = k;
      step();
      if (k == 0) chk("first_cnt", o_wr_count, 1);
      if (k == 14) chk("pre_full", o_mem_full, 0);
    end
    chk("full_flag", o_mem_full, 1);
    chk("full_capt", o_capturing, 0);
    chk("full_cnt", o_wr_count, 16);
    i_sample = 16;
    step();
    i_sample = 17;
    step();
    chk("full_cnt_hold", o_wr_count, 16);
    chk("full_state", dut.state, S_FULL);
    i_sample_valid = 1'b0;
    read_one(4'd5, 5, "full_rd5");
    // back-to-back sweep
    i_read_log = 1'b1;
    step();
    i_addr_log = 4'd0;
    step();
    for (int i = 0; i < 16; i++) begin
      i_addr_log = 4'(i + 1);
      step();
      chk("sweep", o_data_log, 32'(i));
    end
    i_read_log = 1'b0;
    step();
    chk("read_to_full", dut.state, S_FULL);
    chk("read_full_flag", o_mem_full, 1);
    held = o_data_log;
    step();
    step();
    chk("data_hold", o_data_log, held);

    // 3. Decimation 2, sample = cycle index; decim changed mid-capture
    i_run_log = 1'b0;
    step();
    i_run_log = 1'b1;
    i_decim = 4'd2;
    i_sample_valid = 1'b1;
    step();
    chk("dec_restart_full", o_mem_full, 0);
    for (int k = 0; k < 13; k++) begin
      i_sample = k;
      if (k == 5) i_decim = 4'd0;
      step();
    end
    chk("dec_cnt5", o_wr_count, 5);
    i_run_log = 1'b0;
    i_sample_valid = 1'b0;
    step();
    chk("dec_abort_state", dut.state, S_IDLE);
    read_one(4'd4, 12, "dec_rd4");
    read_one(4'd1, 3, "dec_rd1");
    read_one(4'd3, 9, "dec_rd3");

    // 4. Valid every other cycle, decim 1 -> one write per 4 cycles
    i_run_log = 1'b1;
    i_decim = 4'd1;
    step();
    for (int c = 0; c < 16; c++) begin
      i_sample_valid = (c % 2 == 0);
      i_sample = 100 + c;
      step();
      if (c % 4 == 1) chk("gap_cnt", o_wr_count, 5'(c / 4 + 1));
    end
    i_run_log = 1'b0;
    i_sample_valid = 1'b0;
    step();
    chk("gap_cnt_end", o_wr_count, 4);
    read_one(4'd1, 104, "gap_rd1");
    read_one(4'd3, 112, "gap_rd3");

    // 5. Abort after 7 writes, then restart
    i_decim = 4'd0;
    i_run_log = 1'b1;
    step();
    i_sample_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      i_sample = 200 + k;
      step();
    end
    i_run_log = 1'b0;
    i_sample_valid = 1'b0;
    step();
    chk("abort_state", dut.state, S_IDLE);
    chk("abort_cnt", o_wr_count, 7);
    chk("abort_full", o_mem_full, 0);
    chk("abort_capt", o_capturing, 0);
    read_one(4'd6, 206, "abort_rd6");
    i_run_log = 1'b1;
    i_sample_valid = 1'b1;
    i_sample = 300;
    step();
    chk("restart_cnt0", o_wr_count, 0);
    i_sample = 301;
    step();
    chk("restart_cnt1", o_wr_count, 1);
    i_sample_valid = 1'b0;
    i_run_log = 1'b0;
    step();
    read_one(4'd0, 301, "restart_rd0");
    read_one(4'd1, 201, "restart_rd1");

    // 6a. FULL, then run_rise together with read request
    i_run_log = 1'b1;
    step();
    i_sample_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_sample = 400 + k;
      step();
    end
    i_sample_valid = 1'b0;
    chk("e6_full", o_mem_full, 1);
    i_run_log = 1'b0;
    step();
    i_run_log = 1'b1;
    i_read_log = 1'b1;
    step();
    chk("e6_state", dut.state, S_CAPTURE);
    chk("e6_full_clr", o_mem_full, 0);
    chk("e6_capt", o_capturing, 1);
    i_read_log = 1'b0;

    // 6b. Reset mid-capture after 3 writes
    i_sample_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_sample = 500 + k;
      step();
    end
    chk("e6_cnt3", o_wr_count, 3);
    i_rst = 1'b1;
    i_sample = 999;
    step();
    chk("rst_mid_state", dut.state, S_IDLE);
    chk("rst_mid_cnt", o_wr_count, 0);
    chk("rst_mid_capt", o_capturing, 0);
    i_rst = 1'b0;
    i_run_log = 1'b0;
    i_sample_valid = 1'b0;
    step();
    read_one(4'd3, 403, "rst_no_write");
    read_one(4'd2, 502, "rst_kept2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
